// File: rtl/fp64_tx_pkg.sv
// Shared types and constants for the fp64 result transmitter.
// Frame layout: header, product bytes MSB first, flags byte, XOR checksum.
package fp64_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StFlags,
    StCsum
  } tx_state_e;

  localparam logic [7:0]  HDR_BYTE_DFLT = 8'hA5;
  localparam int unsigned FRAME_LEN     = 11;

  // Bit positions inside the 4-bit flags field.
  localparam int unsigned FLG_NAN = 3;
  localparam int unsigned FLG_INF = 2;
  localparam int unsigned FLG_OVF = 1;
  localparam int unsigned FLG_UDF = 0;

  // Byte index width; kept at least 1 so a single-byte product still has a counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_sel_csum.sv
// Picks one product byte from the holding register and keeps the running
// XOR checksum of every byte accepted downstream.
module byte_sel_csum #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] hold,
  input  logic [IDX_W-1:0]  idx,
  output logic [7:0]        sel_byte,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        acc_byte,
  output logic [7:0]        csum
);

  localparam int unsigned NBYTES = DATA_W / 8;

  logic [7:0] csum_d, csum_q;

  // Index 0 is the most significant byte.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_byte = hold[DATA_W-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    csum_d = csum_q;
    if (clr) begin
      csum_d = '0;
    end else if (en) begin
      csum_d = csum_q ^ acc_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/fp64_result_tx.sv
// Serialises one multiplier product plus exception flags into an 11-byte frame
// on a byte-wide valid/ready link, accepting the next product in the checksum cycle.
module fp64_result_tx
  import fp64_tx_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              busy
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  tx_state_e         state_d, state_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [3:0]        hold_flags_q;

  logic       in_fire;
  logic       capture;
  logic       csum_en;
  logic [7:0] sel_byte;
  logic [7:0] csum;
  logic [7:0] flags_byte;

  assign flags_byte = {4'b0000, hold_flags_q[FLG_NAN], hold_flags_q[FLG_INF],
                       hold_flags_q[FLG_OVF], hold_flags_q[FLG_UDF]};

  // in_ready looks at out_ready only in CSUM, so the next frame follows with no bubble.
  assign in_ready  = (state_q == StIdle) || ((state_q == StCsum) && out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q != StIdle);
  assign busy      = (state_q != StIdle);

  always_comb begin
    out_byte = 8'h00;
    unique case (state_q)
      StIdle:  out_byte = 8'h00;
      StHdr:   out_byte = HDR_BYTE;
      StData:  out_byte = sel_byte;
      StFlags: out_byte = flags_byte;
      StCsum:  out_byte = csum;
      default: out_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    csum_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          capture = 1'b1;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (out_ready) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (out_ready) begin
          csum_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = StFlags;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StFlags: begin
        if (out_ready) begin
          csum_en = 1'b1;
          state_d = StCsum;
        end
      end
      StCsum: begin
        if (out_ready) begin
          if (in_fire) begin
            capture = 1'b1;
            state_d = StHdr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      hold_data_q  <= '0;
      hold_flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        hold_data_q  <= in_data;
        hold_flags_q <= in_flags;
      end
    end
  end

  byte_sel_csum #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_byte_sel_csum (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold_data_q),
    .idx     (idx_q),
    .sel_byte(sel_byte),
    .clr     (capture),
    .en      (csum_en),
    .acc_byte(out_byte),
    .csum    (csum)
  );

endmodule

// File: tb/tb_fp64_result_tx.sv
// Directed bench for fp64_result_tx: framing, checksum, backpressure,
// back-to-back frames, mid-frame reset and ignored input pulses.
module tb_fp64_result_tx;
  import fp64_tx_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        busy;

  int n_chk;
  int n_bad;

  fp64_result_tx u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_flags (in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected frame image: header, 8 data bytes, flags byte, hand-computed checksum.
  function automatic logic [87:0] mk_frame(input logic [63:0] d, input logic [3:0] f,
                                           input logic [7:0] cs);
    return {8'hA5, d, 4'b0000, f, cs};
  endfunction

  task automatic send(input string tag, input logic [63:0] d, input logic [3:0] f);
    @(negedge clk);
    in_data  = d;
    in_flags = f;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_rdy"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Consumes one frame. bp applies the 1,0,0,1 out_ready pattern; pulse_at >= 0
  // pulses in_valid with junk when that byte index is current; drop clears
  // in_valid right after the checksum byte is taken.
  task automatic expect_frame(input string tag, input logic [87:0] f, input bit bp,
                              input int pulse_at, input bit drop);
    logic [3:0] pat;
    logic [7:0] held;
    int k;
    int c;
    bit stalled;
    bit pulsed;
    bit pclr;
    bit pnow;
    pat     = 4'b1001;
    k       = 0;
    c       = 0;
    stalled = 1'b0;
    pulsed  = 1'b0;
    pclr    = 1'b0;
    held    = 8'h00;
    while (k < 11 && c < 100) begin
      @(negedge clk);
      out_ready = bp ? pat[3 - (c % 4)] : 1'b1;
      pnow = 1'b0;
      if (pclr) begin
        in_valid = 1'b0;
        pclr     = 1'b0;
      end
      if (pulse_at >= 0 && k == pulse_at && !pulsed) begin
        in_valid = 1'b1;
        in_data  = 64'h0123456789ABCDEF;
        in_flags = 4'hF;
        pulsed   = 1'b1;
        pclr     = 1'b1;
        pnow     = 1'b1;
      end
      #1;
      check($sformatf("%s_vld%0d", tag, c), 64'(out_valid), 64'(1));
      if (stalled) check($sformatf("%s_hold%0d", tag, c), 64'(out_byte), 64'(held));
      if (pnow) check({tag, "_ign_rdy"}, 64'(in_ready), 64'(0));
      if (k == 10 && in_valid) check({tag, "_b2b_rdy"}, 64'(in_ready), 64'(out_ready));
      if (out_ready) begin
        check($sformatf("%s_b%0d", tag, k), 64'(out_byte), 64'(f[87-8*k -: 8]));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_byte;
      end
      c++;
    end
    check({tag, "_done"}, 64'(k), 64'(11));
    if (!bp) check({tag, "_len"}, 64'(c), 64'(FRAME_LEN));
    @(posedge clk);
    #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s_vld%0d", tag, i), 64'(out_valid), 64'(0));
      check($sformatf("%s_busy%0d", tag, i), 64'(busy), 64'(0));
    end
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_flags  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_vld", 64'(out_valid), 64'(0));
    check("rst_byte", 64'(out_byte), 64'(8'h00));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rdy", 64'(in_ready), 64'(1));

    // 1.0, no flags: 3F^F0 = CF
    send("t1", 64'h3FF0000000000000, 4'h0);
    expect_frame("t1", mk_frame(64'h3FF0000000000000, 4'h0, 8'hCF), 1'b0, -1, 1'b0);
    expect_idle("t1_end", 1);

    // +inf with inf|ovf: 7F^F0^06 = 89
    send("t2", 64'h7FF0000000000000, 4'b0110);
    expect_frame("t2", mk_frame(64'h7FF0000000000000, 4'b0110, 8'h89), 1'b0, -1, 1'b0);
    expect_idle("t2_end", 1);

    send("t3", 64'h3FF0000000000000, 4'h0);
    expect_frame("t3", mk_frame(64'h3FF0000000000000, 4'h0, 8'hCF), 1'b1, -1, 1'b0);
    expect_idle("t3_end", 1);

    // Second product held valid through frame 1; must be taken in the CSUM cycle.
    send("t4", 64'h3FF0000000000000, 4'h0);
    in_data  = 64'h4000000000000000;
    in_flags = 4'h0;
    in_valid = 1'b1;
    expect_frame("t4a", mk_frame(64'h3FF0000000000000, 4'h0, 8'hCF), 1'b0, -1, 1'b1);
    expect_frame("t4b", mk_frame(64'h4000000000000000, 4'h0, 8'h40), 1'b0, -1, 1'b0);
    expect_idle("t4_end", 1);

    // Reset after header plus four data bytes.
    send("t5", 64'h3FF0000000000000, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t5_vld", 64'(out_valid), 64'(0));
    check("t5_rdy", 64'(in_ready), 64'(1));
    check("t5_busy", 64'(busy), 64'(0));
    send("t5n", 64'h4000000000000000, 4'h0);
    expect_frame("t5n", mk_frame(64'h4000000000000000, 4'h0, 8'h40), 1'b0, -1, 1'b0);
    expect_idle("t5_end", 1);

    // Junk pulse during DATA must be ignored and must not spawn a frame.
    send("t6", 64'h7FF0000000000000, 4'b0110);
    expect_frame("t6", mk_frame(64'h7FF0000000000000, 4'b0110, 8'h89), 1'b0, 3, 1'b0);
    expect_idle("t6_end", 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
